pe_grid_engine: RTL

//  Parametrised successor to the 2x2 PE array: ROWS x COLS grid of A/B operand regs and S accumulators.

---
 rtl/pe_grid_engine.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pe_grid_engine.sv
// ROWS x COLS processing-element grid: A/B operand registers with S accumulators,
// driven one step per cycle by handshaked commands carrying a repeat count.
module pe_grid_engine #(
  parameter int ROWS             = 2,
  parameter int COLS             = 2,
  parameter int PRECISION        = 8,
  parameter int OUTPUT_PRECISION = 32,
  parameter int WRAP             = 1
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [2:0]                            cmd,
  input  logic [3:0]                            cmd_count,
  input  logic [ROWS*COLS*PRECISION-1:0]        a_load,
  input  logic [ROWS*COLS*PRECISION-1:0]        b_load,
  input  logic [ROWS*COLS*OUTPUT_PRECISION-1:0] s_load,
  output logic [ROWS*COLS*PRECISION-1:0]        A_flat,
  output logic [ROWS*COLS*PRECISION-1:0]        B_flat,
  output logic [ROWS*COLS*OUTPUT_PRECISION-1:0] S_flat,
  output logic                                  busy,
  output logic                                  done
);
  localparam int P  = PRECISION;
  localparam int O  = OUTPUT_PRECISION;
  localparam int AW = ROWS*COLS*P;
  localparam int SW = ROWS*COLS*O;

  localparam logic [2:0] OP_MAC     = 3'd0;
  localparam logic [2:0] OP_UP      = 3'd1;
  localparam logic [2:0] OP_DOWN    = 3'd2;
  localparam logic [2:0] OP_LEFT    = 3'd3;
  localparam logic [2:0] OP_RIGHT   = 3'd4;
  localparam logic [2:0] OP_LOAD_AB = 3'd5;
  localparam logic [2:0] OP_LOAD_S  = 3'd6;
  localparam logic [2:0] OP_CLEAR   = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t         state;
  logic [2:0]     op;
  logic [3:0]     remaining;
  logic [AW-1:0]  a_q, b_q, a_nxt, b_nxt;
  logic [SW-1:0]  s_q, s_nxt;

  function automatic logic [O-1:0] mac_wrap(input logic [O-1:0] acc,
                                            input logic [P-1:0] x,
                                            input logic [P-1:0] y);
    logic [2*P-1:0] prod;
    prod = {{P{1'b0}}, x} * {{P{1'b0}}, y};
    return acc + O'(prod);
  endfunction

  // A cell on the vacated edge takes zero when the grid is not toroidal.
  function automatic logic [P-1:0] edge_pick(input logic at_edge, input logic [P-1:0] nb);
    return (at_edge && WRAP == 0) ? '0 : nb;
  endfunction

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam int IDX = r*COLS + c;
      localparam int SRC_UP = ((r+1) % ROWS)*COLS + c;
      localparam int SRC_DN = ((r+ROWS-1) % ROWS)*COLS + c;
      localparam int SRC_LF = r*COLS + (c+1) % COLS;
      localparam int SRC_RT = r*COLS + (c+COLS-1) % COLS;
      localparam logic EDGE_UP = (r == ROWS-1);
      localparam logic EDGE_DN = (r == 0);
      localparam logic EDGE_LF = (c == COLS-1);
      localparam logic EDGE_RT = (c == 0);

      logic [P-1:0] a_cur, b_cur, a_n, b_n;
      logic [O-1:0] s_cur, s_n;

      assign a_cur = a_q[IDX*P +: P];
      assign b_cur = b_q[IDX*P +: P];
      assign s_cur = s_q[IDX*O +: O];

      always_comb begin
        a_n = a_cur;
        b_n = b_cur;
        s_n = s_cur;
        case (op)
          OP_MAC:     s_n = mac_wrap(s_cur, a_cur, b_cur);
          OP_UP: begin
            a_n = edge_pick(EDGE_UP, a_q[SRC_UP*P +: P]);
            b_n = edge_pick(EDGE_UP, b_q[SRC_UP*P +: P]);
          end
          OP_DOWN: begin
            a_n = edge_pick(EDGE_DN, a_q[SRC_DN*P +: P]);
            b_n = edge_pick(EDGE_DN, b_q[SRC_DN*P +: P]);
          end
          OP_LEFT: begin
            a_n = edge_pick(EDGE_LF, a_q[SRC_LF*P +: P]);
            b_n = edge_pick(EDGE_LF, b_q[SRC_LF*P +: P]);
          end
          OP_RIGHT: begin
            a_n = edge_pick(EDGE_RT, a_q[SRC_RT*P +: P]);
            b_n = edge_pick(EDGE_RT, b_q[SRC_RT*P +: P]);
          end
          OP_LOAD_AB: begin
            a_n = a_load[IDX*P +: P];
            b_n = b_load[IDX*P +: P];
          end
          OP_LOAD_S:  s_n = s_load[IDX*O +: O];
          OP_CLEAR: begin
            a_n = '0;
            b_n = '0;
            s_n = '0;
          end
          default: ;
        endcase
      end

      assign a_nxt[IDX*P +: P] = a_n;
      assign b_nxt[IDX*P +: P] = b_n;
      assign s_nxt[IDX*O +: O] = s_n;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else if (state == EXEC) begin
      a_q <= a_nxt;
      b_q <= b_nxt;
      s_q <= s_nxt;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      op        <= OP_MAC;
      remaining <= 4'd0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd_valid) begin
            op        <= cmd;
            remaining <= (cmd_count == 4'd0) ? 4'd1 : cmd_count;
            state     <= EXEC;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        EXEC: begin
          remaining <= remaining - 4'd1;
          if (remaining == 4'd1) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign A_flat = a_q;
  assign B_flat = b_q;
  assign S_flat = s_q;
endmodule
